// File: rtl/control_unit.sv
// control_unit: Moore-style sequencer for the 8-bit processing unit datapath.
//
// Steps every instruction through fetch (S_fet1, S_fet2), decode (S_dec) and
// an optional execute tail. It drives the datapath load/select strobes and the
// memory write strobe, and reports halt/illegal status plus a retired count.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   instruction    IR contents: [7:4] opcode, [3:2] src reg, [1:0] dest reg
//   Zflag          datapath zero flag (looked at only in S_dec)
//   Load_R0..R3    register-file load strobes
//   Load_PC/Inc_PC program counter load / increment
//   Sel_Bus_1_Mux  0..3 = R0..R3, 4 = PC
//   Sel_Bus_2_Mux  0 = ALU, 1 = Bus_1, 2 = mem_word
//   Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z  datapath register loads
//   write          memory write strobe
//   halted         FSM sits in S_halt
//   illegal_op     sticky flag: an undefined opcode was decoded
//   instr_count    retired-instruction counter (wraps)
//   fsm_state      current FSM state, for observation only
//
// There is no valid/ready handshake here: every output is a pure function of
// the current state (plus instruction/Zflag while in S_dec) and is meaningful
// on every cycle.
module control_unit #(
    parameter int word_size = 8,
    parameter int op_size   = 4,
    parameter int Sel1_size = 3,
    parameter int Sel2_size = 2,
    parameter int cnt_size  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] instruction,
    input  logic                 Zflag,
    output logic                 Load_R0,
    output logic                 Load_R1,
    output logic                 Load_R2,
    output logic                 Load_R3,
    output logic                 Load_PC,
    output logic                 Inc_PC,
    output logic [Sel1_size-1:0] Sel_Bus_1_Mux,
    output logic [Sel2_size-1:0] Sel_Bus_2_Mux,
    output logic                 Load_IR,
    output logic                 Load_Add_R,
    output logic                 Load_Reg_Y,
    output logic                 Load_Reg_Z,
    output logic                 write,
    output logic                 halted,
    output logic                 illegal_op,
    output logic [cnt_size-1:0]  instr_count,
    output logic [3:0]           fsm_state
);

    typedef enum logic [3:0] {
        S_idle = 4'd0,
        S_fet1 = 4'd1,
        S_fet2 = 4'd2,
        S_dec  = 4'd3,
        S_ex1  = 4'd4,
        S_rd1  = 4'd5,
        S_rd2  = 4'd6,
        S_wr1  = 4'd7,
        S_wr2  = 4'd8,
        S_br1  = 4'd9,
        S_br2  = 4'd10,
        S_halt = 4'd11
    } state_t;

    localparam logic [op_size-1:0] OP_NOP = op_size'(4'h0);
    localparam logic [op_size-1:0] OP_ADD = op_size'(4'h1);
    localparam logic [op_size-1:0] OP_SUB = op_size'(4'h2);
    localparam logic [op_size-1:0] OP_AND = op_size'(4'h3);
    localparam logic [op_size-1:0] OP_NOT = op_size'(4'h4);
    localparam logic [op_size-1:0] OP_RD  = op_size'(4'h5);
    localparam logic [op_size-1:0] OP_WR  = op_size'(4'h6);
    localparam logic [op_size-1:0] OP_BR  = op_size'(4'h7);
    localparam logic [op_size-1:0] OP_BRZ = op_size'(4'h8);
    localparam logic [op_size-1:0] OP_HLT = op_size'(4'hF);

    localparam logic [Sel1_size-1:0] SEL1_PC  = Sel1_size'(4);
    localparam logic [Sel2_size-1:0] SEL2_ALU = Sel2_size'(0);
    localparam logic [Sel2_size-1:0] SEL2_B1  = Sel2_size'(1);
    localparam logic [Sel2_size-1:0] SEL2_MEM = Sel2_size'(2);

    state_t             state;
    state_t             next_state;
    logic [op_size-1:0] opcode;
    logic [1:0]         src;
    logic [1:0]         dest;
    logic [3:0]         load_r;
    logic               set_illegal;
    logic               count_en;

    assign opcode    = instruction[word_size-1 -: op_size];
    assign src       = instruction[3:2];
    assign dest      = instruction[1:0];
    assign fsm_state = state;
    assign halted    = (state == S_halt);

    assign Load_R0 = load_r[0];
    assign Load_R1 = load_r[1];
    assign Load_R2 = load_r[2];
    assign Load_R3 = load_r[3];

    // An instruction retires on the edge that returns to S_fet1 from any
    // state that finishes one; the S_idle -> S_fet1 start-up edge does not.
    assign count_en = (next_state == S_fet1) &&
                      (state == S_dec || state == S_ex1 || state == S_rd2 ||
                       state == S_wr2 || state == S_br2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_idle;
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if (set_illegal) begin
                illegal_op <= 1'b1;
            end
            if (count_en) begin
                instr_count <= instr_count + cnt_size'(1);
            end
        end
    end

    always_comb begin
        next_state    = state;
        load_r        = 4'b0000;
        Load_PC       = 1'b0;
        Inc_PC        = 1'b0;
        Sel_Bus_1_Mux = '0;
        Sel_Bus_2_Mux = '0;
        Load_IR       = 1'b0;
        Load_Add_R    = 1'b0;
        Load_Reg_Y    = 1'b0;
        Load_Reg_Z    = 1'b0;
        write         = 1'b0;
        set_illegal   = 1'b0;

        case (state)
            S_idle: begin
                next_state = S_fet1;
            end
            S_fet1: begin
                Sel_Bus_1_Mux = SEL1_PC;
                Sel_Bus_2_Mux = SEL2_B1;
                Load_Add_R    = 1'b1;
                Inc_PC        = 1'b1;
                next_state    = S_fet2;
            end
            S_fet2: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_IR       = 1'b1;
                next_state    = S_dec;
            end
            S_dec: begin
                case (opcode)
                    OP_NOP: next_state = S_fet1;
                    OP_ADD, OP_SUB, OP_AND: begin
                        Sel_Bus_1_Mux = Sel1_size'(src);
                        Sel_Bus_2_Mux = SEL2_B1;
                        Load_Reg_Y    = 1'b1;
                        next_state    = S_ex1;
                    end
                    OP_NOT: begin
                        Sel_Bus_1_Mux = Sel1_size'(src);
                        Sel_Bus_2_Mux = SEL2_ALU;
                        Load_Reg_Z    = 1'b1;
                        load_r        = 4'b0001 << dest;
                        next_state    = S_fet1;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        Sel_Bus_1_Mux = SEL1_PC;
                        Sel_Bus_2_Mux = SEL2_B1;
                        Load_Add_R    = 1'b1;
                        if (opcode == OP_RD) begin
                            next_state = S_rd1;
                        end else if (opcode == OP_WR) begin
                            next_state = S_wr1;
                        end else begin
                            next_state = S_br1;
                        end
                    end
                    OP_BRZ: begin
                        if (Zflag) begin
                            Sel_Bus_1_Mux = SEL1_PC;
                            Sel_Bus_2_Mux = SEL2_B1;
                            Load_Add_R    = 1'b1;
                            next_state    = S_br1;
                        end else begin
                            // Not taken: step over the branch-target byte.
                            Inc_PC     = 1'b1;
                            next_state = S_fet1;
                        end
                    end
                    OP_HLT: next_state = S_halt;
                    default: begin
                        set_illegal = 1'b1;
                        next_state  = S_halt;
                    end
                endcase
            end
            S_ex1: begin
                Sel_Bus_1_Mux = Sel1_size'(dest);
                Sel_Bus_2_Mux = SEL2_ALU;
                Load_Reg_Z    = 1'b1;
                load_r        = 4'b0001 << dest;
                next_state    = S_fet1;
            end
            S_rd1, S_wr1: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_Add_R    = 1'b1;
                Inc_PC        = 1'b1;
                next_state    = (state == S_rd1) ? S_rd2 : S_wr2;
            end
            S_rd2: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                load_r        = 4'b0001 << dest;
                next_state    = S_fet1;
            end
            S_wr2: begin
                Sel_Bus_1_Mux = Sel1_size'(src);
                write         = 1'b1;
                next_state    = S_fet1;
            end
            S_br1: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_Add_R    = 1'b1;
                next_state    = S_br2;
            end
            S_br2: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_PC       = 1'b1;
                next_state    = S_fet1;
            end
            S_halt: begin
                next_state = S_halt;
            end
            default: begin
                next_state = S_idle;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: directed instruction sequences. Each cycle the
// driver pushes the hand-computed output vector for that cycle into exp_q; a
// separate monitor pops and compares on every falling edge.
module tb_control_unit;

    localparam int W = 34;

    logic        clk;
    logic        rst;
    logic [7:0]  instruction;
    logic        Zflag;
    logic        Load_R0, Load_R1, Load_R2, Load_R3;
    logic        Load_PC, Inc_PC;
    logic [2:0]  Sel_Bus_1_Mux;
    logic [1:0]  Sel_Bus_2_Mux;
    logic        Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z;
    logic        write, halted, illegal_op;
    logic [15:0] instr_count;
    logic [3:0]  fsm_state;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           compared;
    int           mismatched;

    control_unit dut (
        .clk           (clk),
        .rst           (rst),
        .instruction   (instruction),
        .Zflag         (Zflag),
        .Load_R0       (Load_R0),
        .Load_R1       (Load_R1),
        .Load_R2       (Load_R2),
        .Load_R3       (Load_R3),
        .Load_PC       (Load_PC),
        .Inc_PC        (Inc_PC),
        .Sel_Bus_1_Mux (Sel_Bus_1_Mux),
        .Sel_Bus_2_Mux (Sel_Bus_2_Mux),
        .Load_IR       (Load_IR),
        .Load_Add_R    (Load_Add_R),
        .Load_Reg_Y    (Load_Reg_Y),
        .Load_Reg_Z    (Load_Reg_Z),
        .write         (write),
        .halted        (halted),
        .illegal_op    (illegal_op),
        .instr_count   (instr_count),
        .fsm_state     (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    // ---------------- expected-vector helpers ----------------
    // Vector layout: {Load_R3..R0, Load_PC, Inc_PC, Sel1, Sel2, Load_IR,
    //                 Load_Add_R, Load_Reg_Y, Load_Reg_Z, write, halted,
    //                 illegal_op, instr_count}
    function automatic logic [W-1:0] v(input logic [3:0] ldr, input logic ldpc, input logic incpc,
                                       input logic [2:0] s1, input logic [1:0] s2,
                                       input logic ldir, input logic ldadd, input logic ldy,
                                       input logic ldz, input logic wr, input logic hlt,
                                       input logic ill, input logic [15:0] cnt);
        return {ldr, ldpc, incpc, s1, s2, ldir, ldadd, ldy, ldz, wr, hlt, ill, cnt};
    endfunction

    function automatic logic [W-1:0] f_zero(input logic [15:0] c);
        return v(4'b0000, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, c);
    endfunction
    function automatic logic [W-1:0] f_fet1(input logic [15:0] c);
        return v(4'b0000, 0, 1, 3'd4, 2'd1, 0, 1, 0, 0, 0, 0, 0, c);
    endfunction
    function automatic logic [W-1:0] f_fet2(input logic [15:0] c);
        return v(4'b0000, 0, 0, 3'd0, 2'd2, 1, 0, 0, 0, 0, 0, 0, c);
    endfunction
    // decode of RD / WR / BR / BRZ-taken: PC onto address register
    function automatic logic [W-1:0] f_adr(input logic [15:0] c);
        return v(4'b0000, 0, 0, 3'd4, 2'd1, 0, 1, 0, 0, 0, 0, 0, c);
    endfunction
    // S_rd1 / S_wr1
    function automatic logic [W-1:0] f_op1(input logic [15:0] c);
        return v(4'b0000, 0, 1, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0, 0, c);
    endfunction
    function automatic logic [W-1:0] f_br1(input logic [15:0] c);
        return v(4'b0000, 0, 0, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0, 0, c);
    endfunction
    function automatic logic [W-1:0] f_br2(input logic [15:0] c);
        return v(4'b0000, 1, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0, 0, c);
    endfunction
    function automatic logic [W-1:0] f_halt(input logic ill, input logic [15:0] c);
        return v(4'b0000, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 1, ill, c);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic [7:0] instr, input logic z, input logic [W-1:0] e, input string nm);
        @(posedge clk);
        #1;
        instruction = instr;
        Zflag       = z;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Assert reset between edges; outputs must clear before the falling edge.
    task automatic cyc_arst(input string nm);
        @(posedge clk);
        #3;
        rst = 1'b0;
        exp_q.push_back(f_zero(16'd0));
        name_q.push_back(nm);
    endtask

    task automatic release_rst(input string nm);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.push_back(f_zero(16'd0));
        name_q.push_back(nm);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [W-1:0] act;
    assign act = {Load_R3, Load_R2, Load_R1, Load_R0, Load_PC, Inc_PC, Sel_Bus_1_Mux,
                  Sel_Bus_2_Mux, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, write,
                  halted, illegal_op, instr_count};

    always @(negedge clk) begin
        logic [W-1:0] e;
        string        nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            compared = compared + 1;
            if (act !== e) begin
                mismatched = mismatched + 1;
                $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, e, $time);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        compared    = 0;
        mismatched  = 0;
        rst         = 1'b0;
        instruction = 8'h00;
        Zflag       = 1'b0;

        cyc(8'h00, 0, f_zero(0), "reset_state");
        release_rst("idle_after_release");

        // NOP: 3 cycles
        cyc(8'h00, 0, f_fet1(0), "nop_fet1");
        cyc(8'h00, 0, f_fet2(0), "nop_fet2");
        cyc(8'h00, 0, f_zero(0), "nop_dec");

        // ADD R1 -> R2: 4 cycles
        cyc(8'h16, 0, f_fet1(1), "add_fet1");
        cyc(8'h16, 0, f_fet2(1), "add_fet2");
        cyc(8'h16, 0, v(4'b0000, 0, 0, 3'd1, 2'd1, 0, 0, 1, 0, 0, 0, 0, 16'd1), "add_dec");
        cyc(8'h16, 0, v(4'b0100, 0, 0, 3'd2, 2'd0, 0, 0, 0, 1, 0, 0, 0, 16'd1), "add_ex1");

        // RD into R3: 5 cycles
        cyc(8'h53, 0, f_fet1(2), "rd_fet1");
        cyc(8'h53, 0, f_fet2(2), "rd_fet2");
        cyc(8'h53, 0, f_adr(2), "rd_dec");
        cyc(8'h53, 0, f_op1(2), "rd_rd1");
        cyc(8'h53, 0, v(4'b1000, 0, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 16'd2), "rd_rd2");

        // WR from R0: 5 cycles, write high only in wr2
        cyc(8'h60, 0, f_fet1(3), "wr_fet1");
        cyc(8'h60, 0, f_fet2(3), "wr_fet2");
        cyc(8'h60, 0, f_adr(3), "wr_dec");
        cyc(8'h60, 0, f_op1(3), "wr_wr1");
        cyc(8'h60, 0, v(4'b0000, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 16'd3), "wr_wr2");

        // NOT src R3 -> dest R1: 3 cycles
        cyc(8'h4D, 0, f_fet1(4), "not_fet1");
        cyc(8'h4D, 0, f_fet2(4), "not_fet2");
        cyc(8'h4D, 0, v(4'b0010, 0, 0, 3'd3, 2'd0, 0, 0, 0, 1, 0, 0, 0, 16'd4), "not_dec");

        // BRZ not taken: Inc_PC only
        cyc(8'h80, 0, f_fet1(5), "brz_nt_fet1");
        cyc(8'h80, 0, f_fet2(5), "brz_nt_fet2");
        cyc(8'h80, 0, v(4'b0000, 0, 1, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 16'd5), "brz_nt_dec");

        // BRZ taken: Zflag high only during decode
        cyc(8'h80, 0, f_fet1(6), "brz_t_fet1");
        cyc(8'h80, 0, f_fet2(6), "brz_t_fet2");
        cyc(8'h80, 1, f_adr(6), "brz_t_dec");
        cyc(8'h80, 0, f_br1(6), "brz_t_br1");
        cyc(8'h80, 0, f_br2(6), "brz_t_br2");

        // BR: taken regardless of Zflag
        cyc(8'h70, 0, f_fet1(7), "br_fet1");
        cyc(8'h70, 0, f_fet2(7), "br_fet2");
        cyc(8'h70, 0, f_adr(7), "br_dec");
        cyc(8'h70, 0, f_br1(7), "br_br1");
        cyc(8'h70, 0, f_br2(7), "br_br2");

        // SUB src R2 -> dest R3
        cyc(8'h2B, 0, f_fet1(8), "sub_fet1");
        cyc(8'h2B, 0, f_fet2(8), "sub_fet2");
        cyc(8'h2B, 0, v(4'b0000, 0, 0, 3'd2, 2'd1, 0, 0, 1, 0, 0, 0, 0, 16'd8), "sub_dec");
        cyc(8'h2B, 0, v(4'b1000, 0, 0, 3'd3, 2'd0, 0, 0, 0, 1, 0, 0, 0, 16'd8), "sub_ex1");

        // Illegal opcode A: halt with sticky flag, count frozen at 9
        cyc(8'hA0, 0, f_fet1(9), "ill_fet1");
        cyc(8'hA0, 0, f_fet2(9), "ill_fet2");
        cyc(8'hA0, 0, f_zero(9), "ill_dec");
        for (int i = 0; i < 20; i++) begin
            cyc((i % 2 == 0) ? 8'h00 : 8'h16, i[0], f_halt(1'b1, 16'd9), "ill_halt_hold");
        end

        // Asynchronous reset out of halt clears flag and count
        cyc_arst("arst_from_halt");
        release_rst("idle_after_halt_reset");

        // NOP then RD interrupted by reset in S_rd1
        cyc(8'h00, 0, f_fet1(0), "nop2_fet1");
        cyc(8'h00, 0, f_fet2(0), "nop2_fet2");
        cyc(8'h00, 0, f_zero(0), "nop2_dec");
        cyc(8'h53, 0, f_fet1(1), "rd2_fet1");
        cyc(8'h53, 0, f_fet2(1), "rd2_fet2");
        cyc(8'h53, 0, f_adr(1), "rd2_dec");
        cyc_arst("arst_in_rd1");
        release_rst("idle_after_rd1_reset");

        // HLT: halted without illegal flag
        cyc(8'hF0, 0, f_fet1(0), "hlt_fet1");
        cyc(8'hF0, 0, f_fet2(0), "hlt_fet2");
        cyc(8'hF0, 0, f_zero(0), "hlt_dec");
        for (int i = 0; i < 3; i++) begin
            cyc(8'h00, 1, f_halt(1'b0, 16'd0), "hlt_hold");
        end

        @(negedge clk);
        #1;
        compared = compared + 1;
        if (exp_q.size() != 0) begin
            mismatched = mismatched + 1;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Moore-style sequencer for the 8-bit processing unit datapath (R0..R3, PC, IR, Add_R, Reg_Y, Reg_Z, two bus muxes).
- Drives every datapath load/select strobe through a fetch / decode / execute sequence, using IR contents and Zflag.
- Also drives the memory write strobe.
- Reports halt / illegal-opcode status and a retired-instruction count.

Parameters:
- word_size, 8, datapath and instruction width
- op_size, 4, opcode width (instruction[7:4])
- Sel1_size, 3, width of Sel_Bus_1_Mux
- Sel2_size, 2, width of Sel_Bus_2_Mux
- cnt_size, 16, width of instr_count

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- instruction  input  word_size  IR contents: [7:4] opcode, [3:2] src reg, [1:0] dest reg
- Zflag  input  1  zero flag from datapath
- Load_R0, Load_R1, Load_R2, Load_R3  output  1 each  register load strobes
- Load_PC, Inc_PC  output  1 each  PC load / increment
- Sel_Bus_1_Mux  output  Sel1_size  0..3 = R0..R3, 4 = PC
- Sel_Bus_2_Mux  output  Sel2_size  0 = ALU, 1 = Bus_1, 2 = mem_word
- Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z  output  1 each  datapath register loads
- write  output  1  memory write strobe
- halted  output  1  state is S_halt
- illegal_op  output  1  sticky; set when an undefined opcode is decoded
- instr_count  output  cnt_size  retired-instruction counter

Behaviour:
- State register: async clear to S_idle while rst=0. illegal_op and instr_count clear to 0 asynchronously.
- All strobe outputs are combinational decode of state (plus instruction and Zflag in S_dec).
- Unlisted strobes are 0. Unlisted selects are 0.
- In S_idle all outputs are 0.
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8, HLT=F. Codes 9..E are illegal.
- Register strobe mapping: "load dest" asserts Load_R[dest]; "sel src/dest" drives Sel_Bus_1_Mux = that register index.
- State transitions and outputs:
  - S_idle: -> S_fet1 on first clock after reset release.
  - S_fet1: Sel1=4, Sel2=1, Load_Add_R, Inc_PC -> S_fet2.
  - S_fet2: Sel2=2, Load_IR -> S_dec.
  - S_dec, by opcode:
    - NOP: -> S_fet1.
    - ADD/SUB/AND: sel src, Sel2=1, Load_Reg_Y -> S_ex1.
    - NOT: sel src, Sel2=0, Load_Reg_Z, load dest -> S_fet1.
    - RD/WR/BR: Sel1=4, Sel2=1, Load_Add_R -> S_rd1 / S_wr1 / S_br1 respectively.
    - BRZ, Zflag=1: as BR -> S_br1.
    - BRZ, Zflag=0: Inc_PC (skip address byte) -> S_fet1.
    - HLT: -> S_halt.
    - illegal: set illegal_op -> S_halt.
  - S_ex1: sel dest, Sel2=0, Load_Reg_Z, load dest -> S_fet1.
  - S_rd1: Sel2=2, Load_Add_R, Inc_PC -> S_rd2.
  - S_rd2: Sel2=2, load dest -> S_fet1.
  - S_wr1: Sel2=2, Load_Add_R, Inc_PC -> S_wr2.
  - S_wr2: sel src, write -> S_fet1.
  - S_br1: Sel2=2, Load_Add_R -> S_br2.
  - S_br2: Sel2=2, Load_PC -> S_fet1.
  - S_halt: all strobes 0, halted=1. Exit only via reset.
- Latency, counted from entering S_fet1: NOP 3 cycles, NOT 3, ALU op 4, BRZ not-taken 3, RD/WR/BR/BRZ taken 5.
- Zflag is sampled only in S_dec.
- instr_count:
  - +1 on each edge entering S_fet1 from S_dec, S_ex1, S_rd2, S_wr2 or S_br2.
  - Not incremented from S_idle, and not incremented for HLT or illegal opcodes.
  - Wraps from all-ones to 0.
- No strobe combination other than those listed is ever produced. Load_PC and Inc_PC are never asserted together.
- Reset mid-instruction: all outputs are 0 immediately (asynchronously). The next instruction fetch begins from S_fet1 one cycle after release.

Test Plan:
- Reset release, instruction=8'h00 (NOP) -> fet1 shows Sel1=4, Sel2=1, Load_Add_R=1, Inc_PC=1; fet2 shows Load_IR=1, Sel2=2; back in fet1 after 3 cycles; instr_count=1.
- ADD R1->R2 (8'h16) -> dec: Sel1=1, Sel2=1, Load_Reg_Y=1; ex1: Sel1=2, Sel2=0, Load_Reg_Z=1, Load_R2=1; 4 cycles total.
- RD R3 (8'h53) then WR R0 src (8'h60) -> rd2: Load_R3=1, Sel2=2; wr2: Sel1=0, write=1; write high exactly one cycle; instr_count +2.
- BRZ (8'h80) with Zflag=0 -> Inc_PC=1 in dec, no Load_PC. With Zflag=1 -> br2: Load_PC=1, Sel2=2; 5 cycles.
- Opcode 4'hA (8'hA0) -> illegal_op=1, halted=1. All strobes stay 0 for 20 cycles; instr_count unchanged. HLT (8'hF0) -> halted=1, illegal_op=0.
- Assert rst in S_rd1 -> outputs 0 asynchronously, instr_count=0, illegal_op=0. After release: S_idle, then S_fet1 next cycle.
